cdb_arbiter: RTL and testbench

//  Shares the single Common Data Bus between NUM_REQ functional-unit completion ports.

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_arbiter_rr_picker.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 107 ++++++++++
 tb/tb_cdb_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the Common Data Bus arbiter: default sizes and the
// broadcast packet layout that the dispatch/issue stage consumes.
package cdb_arbiter_pkg;

    // Number of functional-unit completion ports sharing the CDB.
    localparam int NUM_FU_CDB = 4;
    // ROB index width carried on the CDB.
    localparam int CDB_TAG_W  = 5;
    // Result width carried on the CDB.
    localparam int CDB_DATA_W = 32;

    // One CDB broadcast. cdb_valid/cdb_tag/cdb_value map 1:1 onto these fields.
    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr,
// searching upward and wrapping. The request vector is doubled, the lower copy
// is masked below ptr, find-first runs on the result and the index is folded
// back into 0..NUM_REQ-1. The unmasked upper copy supplies the wrap-around.
module cdb_arbiter_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [2*NUM_REQ-1:0] req_dbl_s;
    logic [2*NUM_REQ-1:0] masked_s;
    logic [IDX_W:0]       first_s;
    logic                 found_s;

    // Double the request vector and drop the lower-copy bits below ptr.
    always_comb begin
        req_dbl_s = {req, req};
        masked_s  = '0;
        for (int j = 0; j < 2*NUM_REQ; j++) begin
            masked_s[j] = req_dbl_s[j] & (j >= int'(ptr));
        end
    end

    // Find the lowest set bit of the masked double-width vector.
    always_comb begin
        found_s = 1'b0;
        first_s = '0;
        for (int j = 0; j < 2*NUM_REQ; j++) begin
            if (masked_s[j] && !found_s) begin
                found_s = 1'b1;
                first_s = (IDX_W+1)'(j);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Fold the double-width index back onto a port number and build the one-hot grant.
    always_comb begin
        grant = '0;
        if (first_s >= (IDX_W+1)'(NUM_REQ)) begin
            winner = IDX_W'(first_s - (IDX_W+1)'(NUM_REQ));
        end else begin
            winner = first_s[IDX_W-1:0];
        end
        if (found_s) begin
            grant[winner] = 1'b1;
        end else begin
            grant = '0;
        end
        any = found_s;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: each cycle grants at most one completing functional
// unit by round-robin and broadcasts its ROB tag and result on the registered
// CDB one cycle later. Squash blocks consumption; reset wins over squash.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_FU_CDB,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_value,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_value
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   ptr_next_s;
    logic [NUM_REQ-1:0] pick_grant_s;
    logic [IDX_W-1:0]   pick_winner_s;
    logic               pick_any_s;
    logic               take_s;
    logic [TAG_W-1:0]   tag_sel_s;
    logic [DATA_W-1:0]  value_sel_s;
    logic               cdb_valid_r;
    logic [TAG_W-1:0]   cdb_tag_r;
    logic [DATA_W-1:0]  cdb_value_r;

    cdb_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req_valid),
        .ptr    (rr_ptr_r),
        .grant  (pick_grant_s),
        .winner (pick_winner_s),
        .any    (pick_any_s)
    );

    // A result is consumed only when someone requests and neither reset nor squash is active.
    always_comb begin
        if (reset || squash) begin
            take_s = 1'b0;
            grant  = '0;
        end else begin
            take_s = pick_any_s;
            grant  = pick_grant_s;
        end
    end

    // Pointer moves to the port just past the winner, wrapping at the last port.
    always_comb begin
        if (pick_winner_s == IDX_W'(NUM_REQ-1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_winner_s + IDX_W'(1);
        end
    end

    // Select the winning port's tag and value using the picker's one-hot grant.
    always_comb begin
        tag_sel_s   = '0;
        value_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant_s[i]) begin
                tag_sel_s   = req_tag[i*TAG_W +: TAG_W];
                value_sel_s = req_value[i*DATA_W +: DATA_W];
            end else begin
                tag_sel_s   = tag_sel_s;
                value_sel_s = value_sel_s;
            end
        end
    end

    // CDB output register and round-robin pointer; tag/value hold when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_r    <= '0;
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= '0;
            cdb_value_r <= '0;
        end else if (take_s) begin
            rr_ptr_r    <= ptr_next_s;
            cdb_valid_r <= 1'b1;
            cdb_tag_r   <= tag_sel_s;
            cdb_value_r <= value_sel_s;
        end else begin
            rr_ptr_r    <= rr_ptr_r;
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= cdb_tag_r;
            cdb_value_r <= cdb_value_r;
        end
    end

    assign cdb_valid = cdb_valid_r;
    assign cdb_tag   = cdb_tag_r;
    assign cdb_value = cdb_value_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a table of per-cycle vectors (inputs, expected
// grant, expected CDB contents) plus hand-written back-to-back and starvation sequences.
module tb_cdb_arbiter;

    logic         clock;
    logic         reset;
    logic         squash;
    logic [3:0]   req_valid;
    logic [19:0]  req_tag;
    logic [127:0] req_value;
    logic [3:0]   grant;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_value;

    int n_checks;
    int n_fail;

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(5), .DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .grant     (grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        sq;
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        logic        chk_cdb;
        logic        exp_valid;
        logic        chk_tv;
        logic [4:0]  exp_tag;
        logic [31:0] exp_value;
    } vec_t;

    vec_t vecs[$];

    // Fixed per-FU results: FU0 tag 1, FU1 tag 3, FU2 tag 7, FU3 tag 9.
    localparam logic [19:0]  FIX_TAG = {5'd9, 5'd7, 5'd3, 5'd1};
    localparam logic [127:0] FIX_VAL = {32'h3333_3333, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};

    task automatic add(input logic rst, input logic sq, input logic [3:0] req,
                       input logic [3:0] g, input logic cc, input logic v,
                       input logic ct, input logic [4:0] t, input logic [31:0] d);
        vec_t r;
        r.rst = rst; r.sq = sq; r.req = req; r.exp_grant = g;
        r.chk_cdb = cc; r.exp_valid = v; r.chk_tv = ct; r.exp_tag = t; r.exp_value = d;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        squash    = 1'b0;
        req_valid = 4'b0000;
        req_tag   = FIX_TAG;
        req_value = FIX_VAL;

        //   rst   sq    req      grant    cc    v     ct    tag    value
        // Reset held two cycles with everyone requesting; FU0 first after release.
        add(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        add(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0);
        // Full contention from rr_ptr=0: grants 0,1,2,3, broadcasts back-to-back.
        add(1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0);
        add(1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1111_1111);
        add(1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b1, 1'b1, 5'd3, 32'h2222_2222);
        add(1'b0, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 5'd9, 32'h3333_3333);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        // Lone requester FU2 (tag 7, 0xDEADBEEF), ptr=0.
        add(1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        // Wrap with ptr=3: FU3, then FU0 even though FU3 re-requests, then FU3.
        add(1'b0, 1'b0, 4'b1001, 4'b1000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        add(1'b0, 1'b0, 4'b1001, 4'b0001, 1'b1, 1'b1, 1'b1, 5'd9, 32'h3333_3333);
        add(1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1111_1111);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 5'd9, 32'h3333_3333);
        // Bring ptr to 1, then squash with req=0011: no grant, prior broadcast visible.
        add(1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        add(1'b0, 1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1111_1111);
        // After squash ptr is still 1, so FU1 wins; then ptr=2 search wraps to FU0.
        add(1'b0, 1'b0, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        add(1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 5'd3, 32'h2222_2222);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1111_1111);
        // Reset together with squash: reset wins, everything cleared.
        add(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0);
        // Reset mid-burst with FU1..3 pending; ptr returns to 0 so FU1 beats FU3 afterwards.
        add(1'b0, 1'b0, 4'b1110, 4'b0010, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0);
        add(1'b0, 1'b0, 4'b1100, 4'b0100, 1'b1, 1'b1, 1'b1, 5'd3, 32'h2222_2222);
        add(1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        add(1'b0, 1'b0, 4'b1010, 4'b0010, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0);
        add(1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 5'd3, 32'h2222_2222);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 5'd9, 32'h3333_3333);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

        // Table walk: drive on the falling edge, compare shortly after.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset     = vecs[i].rst;
            squash    = vecs[i].sq;
            req_valid = vecs[i].req;
            #1;
            check("grant", i, {28'd0, grant}, {28'd0, vecs[i].exp_grant});
            if (vecs[i].chk_cdb) begin
                check("cdb_valid", i, {31'd0, cdb_valid}, {31'd0, vecs[i].exp_valid});
            end
            if (vecs[i].chk_tv) begin
                check("cdb_tag", i, {27'd0, cdb_tag}, {27'd0, vecs[i].exp_tag});
                check("cdb_value", i, cdb_value, vecs[i].exp_value);
            end
        end

        // FU1 alone presents a fresh result every cycle: one broadcast per cycle, no bubbles.
        // ptr is 0 here.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k < 3) begin
                req_valid = 4'b0010;
                req_tag[9:5]    = 5'(20 + k);
                req_value[63:32] = 32'h1000_0000 + 32'(k);
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            check("b2b_grant", 100 + k, {28'd0, grant}, (k < 3) ? 32'h2 : 32'h0);
            if (k > 0) begin
                check("b2b_valid", 100 + k, {31'd0, cdb_valid}, 32'h1);
                check("b2b_tag", 100 + k, {27'd0, cdb_tag}, 32'(20 + k - 1));
                check("b2b_value", 100 + k, cdb_value, 32'h1000_0000 + 32'(k - 1));
            end
        end

        // Starvation bound: ptr=2 with all four requesting, FU1 is last in line (cycle 3).
        begin
            int got_at;
            got_at    = -1;
            req_tag   = FIX_TAG;
            req_value = FIX_VAL;
            for (int c = 0; c < 4; c++) begin
                @(negedge clock);
                req_valid = 4'b1111;
                #1;
                check("onehot", 200 + c, {31'd0, $onehot(grant)}, 32'h1);
                if (grant[1] && got_at < 0) begin
                    got_at = c;
                end
            end
            check("starve_cycle", 204, 32'(got_at), 32'd3);
            @(negedge clock);
            req_valid = 4'b0000;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
